// File: rtl/sm_uart_pkg.sv
// sm_uart_pkg: shared constants for the schoolMIPS UART receiver.
//   uart_state_t        receiver FSM state encoding
//   SM_UART_DIV_115200  clocks per bit at 50 MHz / 115200 baud
//   SM_UART_FRAME_BITS  bits per frame, start and stop included
// Build macro: SM_UART_RX_PARITY_EN selects 8E1 framing (11 bits)
// instead of the default 8N1 framing (10 bits).
package sm_uart_pkg;

    localparam int SM_UART_DIV_115200 = 434;

`ifdef SM_UART_RX_PARITY_EN
    localparam int SM_UART_FRAME_BITS = 11;
`else
    localparam int SM_UART_FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sm_sync2.sv
// sm_sync2: two-flop synchroniser for asynchronous single-bit inputs
// (UART rx, buttons, switches).
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset; both flops load RESET_VAL
//   d    asynchronous input
//   q    synchronised output, two clocks behind d
module sm_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sm_uart_rx.sv
// sm_uart_rx: UART receiver. It deserialises frames from the rx pin and
// presents each byte on a valid/ready holding register. Framing, parity and
// overrun errors are reported as one-cycle pulses.
// Build macro: SM_UART_RX_PARITY_EN. When it is defined, frames are 8E1 and
// parity_err is live. When it is undefined, frames are 8N1 and parity_err is
// tied to 0.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset; aborts any frame silently
//   rx          serial line, asynchronous, idle high
//   rx_data     received byte, stable while rx_valid=1
//   rx_valid    byte available
//   rx_ready    consumer accepts the byte (transfer on rx_valid & rx_ready)
//   busy        frame in progress
//   frame_err   pulse: stop bit sampled low
//   parity_err  pulse: even-parity mismatch
//   overrun     pulse: good byte dropped because the holding register is full
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle, waiting for rxs low
// START  | wait half a bit, confirm the start bit (high = glitch)
// DATA   | sample 8 data bits at mid-bit, LSB first
// PARITY | sample the parity bit (parity build only)
// STOP   | sample the stop bit, deliver or reject the byte, then IDLE
module sm_uart_rx
    import sm_uart_pkg::*;
#(
    parameter int DIVISOR = SM_UART_DIV_115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int CW = $clog2(DIVISOR);
    localparam int HALF = DIVISOR / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);

    logic        rxs;
    uart_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        take;

    sm_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    // The holding register counts as free when it is empty or being emptied
    // in this same cycle.
    assign take = !rx_valid || rx_ready;

`ifdef SM_UART_RX_PARITY_EN
    logic par_fault;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SM_UART_RX_PARITY_EN
            par_fault  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SM_UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // A load in STOP below overrides this clear.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rxs;
                        if (idx == 3'd7) begin
`ifdef SM_UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef SM_UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        par_fault <= ^{shreg, rxs};
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
`ifdef SM_UART_RX_PARITY_EN
                        end else if (par_fault) begin
                            parity_err <= 1'b1;
`endif
                        end else if (take) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
